adc78h90_scanner: RTL and testbench

//  Autonomous scan controller for the ADC78H90 8-channel 12-bit SPI ADC (PA power/current/temp

---
 rtl/adc78h90_scanner_pkg.sv | 20 ++
 rtl/adc78h90_scanner_if.sv | 24 ++
 rtl/adc78h90_scanner_chan_sel.sv | 20 ++
 rtl/adc78h90_scanner.sv | 177 +++++++++++++++++
 tb/tb_adc78h90_scanner.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc78h90_scanner_pkg.sv
// Shared constants, FSM state type and control-word helper for the ADC78H90 scanner.
package adc78h90_scanner_pkg;

    localparam int unsigned ADC78_CH_W       = 3;
    localparam int unsigned ADC78_DATA_W     = 12;
    localparam int unsigned ADC78_FRAME_BITS = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } state_e;

    // Control word sent MSB first: two don't-care zeros, channel address, then zeros.
    function automatic logic [ADC78_FRAME_BITS-1:0] ctrl_word(input logic [ADC78_CH_W-1:0] add);
        return {2'b00, add, 11'b0};
    endfunction

endpackage

// File: rtl/adc78h90_scanner_if.sv
// ADC78H90 SPI pins plus the tagged result stream produced by the scanner.
interface adc78h90_scanner_if;
    import adc78h90_scanner_pkg::*;

    logic                    adc_sclk;
    logic                    adc_mosi;
    logic                    adc_miso;
    logic                    adc_cs_n;
    logic [ADC78_DATA_W-1:0] result_data;
    logic [ADC78_CH_W-1:0]   result_chan;
    logic                    result_valid;
    logic                    busy;

    modport master (
        output adc_sclk, adc_mosi, adc_cs_n, result_data, result_chan, result_valid, busy,
        input  adc_miso
    );

    modport slave (
        input  adc_sclk, adc_mosi, adc_cs_n, result_data, result_chan, result_valid, busy,
        output adc_miso
    );

endinterface

// File: rtl/adc78h90_scanner_chan_sel.sv
// Next enabled channel strictly above cur, wrapping 7->0; returns cur when no other bit is set.
module adc78h90_scanner_chan_sel
    import adc78h90_scanner_pkg::*;
(
    input  logic [7:0]            mask,
    input  logic [ADC78_CH_W-1:0] cur,
    output logic [ADC78_CH_W-1:0] nxt
);

    // Scan downward so the nearest candidate above cur is the last one assigned.
    always_comb begin
        nxt = cur;
        for (int i = 7; i >= 1; i--) begin
            if (mask[cur + 3'(i)]) begin
                nxt = cur + 3'(i);
            end
        end
    end

endmodule

// File: rtl/adc78h90_scanner.sv
// Autonomous round-robin scan controller for the ADC78H90 8-channel 12-bit SPI ADC.
// Optional build macro ADC78_AVG_EN adds a per-channel IIR average (12.2 state) on results.
module adc78h90_scanner
    import adc78h90_scanner_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_IDLE = 8
) (
    input logic                clk,
    input logic                rst,
    input logic                enable,
    input logic [7:0]          chan_mask,
    adc78h90_scanner_if.master bus
);

    localparam logic [15:0] DivLoad = 16'(CLK_DIV - 1);
    localparam logic [15:0] GapLoad = 16'(CS_IDLE - 1);

    state_e                  state;
    logic [15:0]             cnt;
    logic [3:0]              bit_idx;
    logic [ADC78_DATA_W-1:0] shift;
    logic [ADC78_CH_W-1:0]   addr;
    logic [ADC78_CH_W-1:0]   prev_addr;
    logic                    primed;
    logic                    sclk, mosi, cs_n, valid, busy_q;
    logic [ADC78_DATA_W-1:0] res_data;
    logic [ADC78_CH_W-1:0]   res_chan;

    logic [ADC78_CH_W-1:0]   sel_nxt;
    logic [ADC78_CH_W-1:0]   start_chan;
    logic [15:0]             ctrl;
    logic                    go;
    logic                    frame_end;
    logic [ADC78_DATA_W-1:0] out_data;

    adc78h90_scanner_chan_sel u_chan_sel (
        .mask (chan_mask),
        .cur  (addr),
        .nxt  (sel_nxt)
    );

    // Leaving IDLE reuses the pointer if still enabled, otherwise searches upward from it.
    assign start_chan = chan_mask[addr] ? addr : sel_nxt;
    assign go         = enable && (chan_mask != 8'h00);
    assign ctrl       = ctrl_word(addr);
    assign frame_end  = (state == StShift) && (cnt == 16'd0) && sclk && (bit_idx == 4'd0);

`ifdef ADC78_AVG_EN
    logic [13:0] avg [8];
    logic [7:0]  seeded;
    logic [14:0] diff;
    logic [13:0] avg_nxt;
    logic        emit;

    assign emit = frame_end && primed;

    // IIR step for the channel whose sample is completing; first sample seeds the state.
    always_comb begin
        diff    = {1'b0, shift, 2'b00} - {1'b0, avg[prev_addr]};
        avg_nxt = {shift, 2'b00};
        if (seeded[prev_addr]) begin
            avg_nxt = avg[prev_addr] + 14'($signed(diff) >>> 2);
        end
    end

    assign out_data = avg_nxt[13:2];

    // Averaging storage; only the seed flags are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seeded <= '0;
        end else if (emit) begin
            avg[prev_addr]    <= avg_nxt;
            seeded[prev_addr] <= 1'b1;
        end
    end
`else
    assign out_data = shift;
`endif

    // Frame sequencer: SCLK divider, MOSI/MISO shifting, result capture and channel rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            addr      <= '0;
            prev_addr <= '0;
            primed    <= 1'b0;
            sclk      <= 1'b1;
            mosi      <= 1'b0;
            cs_n      <= 1'b1;
            valid     <= 1'b0;
            busy_q    <= 1'b0;
            res_data  <= '0;
            res_chan  <= '0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (go) begin
                        state  <= StSetup;
                        addr   <= start_chan;
                        cs_n   <= 1'b0;
                        mosi   <= ctrl[15];
                        cnt    <= DivLoad;
                        busy_q <= 1'b1;
                    end
                end
                StSetup: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        state   <= StShift;
                        sclk    <= 1'b0;
                        mosi    <= ctrl[15];
                        bit_idx <= 4'(ADC78_FRAME_BITS - 1);
                        cnt     <= DivLoad;
                    end
                end
                StShift: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (!sclk) begin
                        sclk  <= 1'b1;
                        shift <= {shift[ADC78_DATA_W-2:0], bus.adc_miso};
                        cnt   <= DivLoad;
                    end else if (frame_end) begin
                        // This frame's data belongs to the channel addressed one frame earlier.
                        state     <= StGap;
                        cs_n      <= 1'b1;
                        cnt       <= GapLoad;
                        prev_addr <= addr;
                        primed    <= 1'b1;
                        if (primed) begin
                            valid    <= 1'b1;
                            res_data <= out_data;
                            res_chan <= prev_addr;
                        end
                    end else begin
                        sclk    <= 1'b0;
                        mosi    <= ctrl[bit_idx - 4'd1];
                        bit_idx <= bit_idx - 4'd1;
                        cnt     <= DivLoad;
                    end
                end
                StGap: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (go) begin
                        state <= StSetup;
                        addr  <= sel_nxt;
                        cs_n  <= 1'b0;
                        mosi  <= ctrl[15];
                        cnt   <= DivLoad;
                    end else begin
                        state  <= StIdle;
                        busy_q <= 1'b0;
                        primed <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.adc_sclk     = sclk;
    assign bus.adc_mosi     = mosi;
    assign bus.adc_cs_n     = cs_n;
    assign bus.result_data  = res_data;
    assign bus.result_chan  = res_chan;
    assign bus.result_valid = valid;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_adc78h90_scanner.sv
// Scoreboard bench for adc78h90_scanner with a behavioural ADC78H90 model.
module tb_adc78h90_scanner;
    import adc78h90_scanner_pkg::*;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_IDLE = 8;
    localparam int unsigned FRAME   = 2 * CLK_DIV * 16 + CLK_DIV + CS_IDLE;
    localparam int unsigned FIRST   = 2 * FRAME - CS_IDLE + 1;  // enable -> first valid
    localparam int unsigned BUDGET  = 2 * FRAME + 40;

    typedef struct packed {
        logic [2:0]  chan;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  chan_mask;
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;
    exp_t        exp_q[$];

    adc78h90_scanner_if bus ();

    adc78h90_scanner #(
        .CLK_DIV (CLK_DIV),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .chan_mask (chan_mask),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: DOUT = code of the previously addressed channel, shifted out on SCLK fall.
    logic [11:0] code [8];
    logic [15:0] dout_sr   = '0;
    logic [15:0] din_sr    = '0;
    logic [2:0]  ch_prev   = 3'd0;
    int          rise_cnt  = 0;
    logic        cs_prev   = 1'b1;
    logic        sclk_prev = 1'b1;
    logic        miso_m    = 1'b0;

    assign bus.adc_miso = miso_m;

    always @(bus.adc_cs_n or bus.adc_sclk) begin
        if (cs_prev === 1'b1 && bus.adc_cs_n === 1'b0) begin
            dout_sr  = {4'h0, code[ch_prev]};
            rise_cnt = 0;
        end else if (cs_prev === 1'b0 && bus.adc_cs_n === 1'b1) begin
            if (rise_cnt == 16) ch_prev = din_sr[13:11];
        end
        if (bus.adc_cs_n === 1'b0) begin
            if (sclk_prev === 1'b1 && bus.adc_sclk === 1'b0) begin
                miso_m  = dout_sr[15];
                dout_sr = {dout_sr[14:0], 1'b0};
            end else if (sclk_prev === 1'b0 && bus.adc_sclk === 1'b1) begin
                din_sr   = {din_sr[14:0], bus.adc_mosi};
                rise_cnt = rise_cnt + 1;
            end
        end
        cs_prev   = bus.adc_cs_n;
        sclk_prev = bus.adc_sclk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Pops expectations in order; checks chan/data and, optionally, first-valid latency.
    task automatic drain(input string name, input int n, input int unsigned t0, input bit chk_lat);
        bit          got;
        exp_t        e;
        int unsigned tprev;
        tprev = t0;
        for (int k = 0; k < n; k++) begin
            wait_valid(BUDGET, got);
            compared++;
            if (!got) begin
                mismatched++;
                $display("FAIL %s_timeout: no result_valid for result %0d", name, k);
                break;
            end
            e = exp_q.pop_front();
            compared++;
            if (bus.result_chan !== e.chan) begin
                mismatched++;
                $display("FAIL %s_chan[%0d]: got %0d want %0d", name, k, bus.result_chan, e.chan);
            end
            compared++;
            if (bus.result_data !== e.data) begin
                mismatched++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, k, bus.result_data, e.data);
            end
            if (k == 0 && chk_lat) begin
                compared++;
                if (cyc - t0 != FIRST) begin
                    mismatched++;
                    $display("FAIL %s_latency: got %0d want %0d", name, cyc - t0, FIRST);
                end
            end else if (k > 0) begin
                compared++;
                if (cyc - tprev != FRAME) begin
                    mismatched++;
                    $display("FAIL %s_spacing[%0d]: got %0d want %0d", name, k, cyc - tprev, FRAME);
                end
            end
            tprev = cyc;
        end
    endtask

    task automatic test_reset();
        int nv;
        int ncs;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.adc_cs_n, bus.adc_sclk, bus.adc_mosi, bus.busy} !== 4'b1100) begin
            mismatched++;
            $display("FAIL reset_pins: got cs/sclk/mosi/busy %b%b%b%b want 1100",
                     bus.adc_cs_n, bus.adc_sclk, bus.adc_mosi, bus.busy);
        end
        compared++;
        if ({bus.result_valid, bus.result_chan, bus.result_data} !== 16'h0000) begin
            mismatched++;
            $display("FAIL reset_result: got v=%b c=%0d d=%h want 0", bus.result_valid,
                     bus.result_chan, bus.result_data);
        end
        rst = 1'b0;
        nv  = 0;
        ncs = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) nv++;
            if (bus.adc_cs_n !== 1'b1 || bus.adc_sclk !== 1'b1) ncs++;
        end
        compared++;
        if (nv != 0) begin
            mismatched++;
            $display("FAIL idle_valid: got %0d pulses want 0", nv);
        end
        compared++;
        if (ncs != 0) begin
            mismatched++;
            $display("FAIL idle_pins: got %0d active clks want 0", ncs);
        end
    endtask

    task automatic test_full_scan();
        int unsigned t0;
        do_reset();
        chan_mask = 8'hFF;
        for (int k = 0; k < 10; k++) exp_q.push_back('{chan: 3'(k % 8), data: code[k % 8]});
        enable = 1'b1;
        t0     = cyc;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL scan_busy: got %b want 1", bus.busy);
        end
        drain("scan", 10, t0, 1'b1);
        enable = 1'b0;
    endtask

    task automatic test_sparse();
        int unsigned t0;
        int          seq [5] = '{1, 4, 7, 1, 4};
        do_reset();
        chan_mask = 8'b1001_0010;
        foreach (seq[k]) exp_q.push_back('{chan: 3'(seq[k]), data: code[seq[k]]});
        enable = 1'b1;
        t0     = cyc;
        drain("sparse", 5, t0, 1'b1);
        do_reset();
        chan_mask = 8'h20;
        for (int k = 0; k < 3; k++) exp_q.push_back('{chan: 3'd5, data: code[5]});
        enable = 1'b1;
        t0     = cyc;
        drain("single", 3, t0, 1'b1);
    endtask

    task automatic test_mask_enable();
        int unsigned t0;
        int          nv;
        int          seq [7] = '{0, 1, 0, 2, 3, 2, 3};
        do_reset();
        chan_mask = 8'h03;
        foreach (seq[k]) exp_q.push_back('{chan: 3'(seq[k]), data: code[seq[k]]});
        enable = 1'b1;
        t0     = cyc;
        drain("mask_a", 1, t0, 1'b1);
        repeat (40) @(negedge clk);
        chan_mask = 8'h0C;
        drain("mask_b", 5, 0, 1'b0);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        drain("drop", 1, 0, 1'b0);
        nv = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) nv++;
        end
        compared++;
        if (nv != 0 || bus.busy !== 1'b0 || bus.adc_cs_n !== 1'b1) begin
            mismatched++;
            $display("FAIL drop_idle: got pulses=%0d busy=%b cs_n=%b want 0/0/1", nv, bus.busy,
                     bus.adc_cs_n);
        end
        exp_q.push_back('{chan: 3'd2, data: code[2]});
        enable = 1'b1;
        t0     = cyc;
        drain("reenable", 1, t0, 1'b1);
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int nv;
        do_reset();
        chan_mask = 8'hFF;
        exp_q.push_back('{chan: 3'd0, data: code[0]});
        enable = 1'b1;
        drain("rstmid", 1, cyc, 1'b1);
        repeat (8 + CLK_DIV + 7 * 2 * CLK_DIV + CLK_DIV) @(negedge clk);
        compared++;
        if (bus.adc_cs_n !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_active: got cs_n %b want 0", bus.adc_cs_n);
        end
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        compared++;
        if ({bus.adc_cs_n, bus.adc_sclk, bus.result_valid, bus.busy} !== 4'b1100) begin
            mismatched++;
            $display("FAIL rstmid_pins: got cs/sclk/valid/busy %b%b%b%b want 1100",
                     bus.adc_cs_n, bus.adc_sclk, bus.result_valid, bus.busy);
        end
        compared++;
        if (bus.result_data !== 12'h000) begin
            mismatched++;
            $display("FAIL rstmid_data: got %h want 000", bus.result_data);
        end
        rst = 1'b0;
        nv  = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) nv++;
        end
        compared++;
        if (nv != 0) begin
            mismatched++;
            $display("FAIL rstmid_valid: got %0d pulses want 0", nv);
        end
    endtask

    task automatic test_average();
        int          st;
        int          s;
        int unsigned t0;
        do_reset();
        chan_mask = 8'h04;
        code[2]   = 12'h400;
        st        = 0;
        for (int k = 0; k < 6; k++) begin
            s = (k == 0) ? 'h400 : 'h800;
`ifdef ADC78_AVG_EN
            if (k == 0) st = s * 4;
            else        st = st + ((s * 4 - st) >>> 2);
            exp_q.push_back('{chan: 3'd2, data: 12'(st >> 2)});
`else
            exp_q.push_back('{chan: 3'd2, data: 12'(s)});
`endif
        end
        enable = 1'b1;
        t0     = cyc;
        drain("avg_first", 1, t0, 1'b1);
        code[2] = 12'h800;
        drain("avg_rest", 5, 0, 1'b0);
        enable = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        chan_mask = 8'h00;
        for (int n = 0; n < 8; n++) code[n] = 12'(12'h100 * n + n);
        test_reset();
        test_full_scan();
        test_sparse();
        test_mask_enable();
        test_reset_mid_frame();
        test_average();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
